// File: rtl/link_pkg.sv
// Shared constants, frame-state encoding and payload bit positions for the
// inter-FPGA board link (receiver now, transmitter later).
package link_pkg;

  localparam logic [7:0] LINK_HDR            = 8'hA5;
  localparam int         FRAME_PAYLOAD_BYTES = 6;
  localparam int         PAY_W               = 8 * FRAME_PAYLOAD_BYTES;

  // Positions inside the 48-bit payload vector {P5, P4, P3, P2, P1, P0}
  localparam int COLOR_LSB = 0;
  localparam int COLOR_W   = 42;
  localparam int COL_LSB   = 42;
  localparam int COL_W     = 3;
  localparam int EN0_BIT   = 45;
  localparam int EN1_BIT   = 46;
  localparam int RSVD_BIT  = 47;
  localparam int COL_MAX   = 6;

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_PAYLOAD,
    ST_CHECK,
    ST_COMMIT,
    ST_ERR
  } link_state_t;

endpackage

// File: rtl/uart_byte_rx.sv
// 8N1 LSB-first byte receiver with a 2-FF input synchronizer; pulses
// byte_valid or byte_ferr for one cycle at the middle of the stop bit.
module uart_byte_rx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       byte_ferr
);

  localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BIT_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t         state;
  logic              rxd_p0, rxd_p1, rxd_p2;
  logic [BAUD_W-1:0] cnt;
  logic [2:0]        bit_idx;

  // Synchronizer stages p0/p1; p2 only serves start-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_p0 <= 1'b1;
      rxd_p1 <= 1'b1;
      rxd_p2 <= 1'b1;
    end else begin
      rxd_p0 <= rxd;
      rxd_p1 <= rxd_p0;
      rxd_p2 <= rxd_p1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      byte_valid <= 1'b0;
      byte_ferr  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      byte_ferr  <= 1'b0;
      case (state)
        RX_IDLE: begin
          cnt <= '0;
          if (rxd_p2 && !rxd_p1) state <= RX_START;
        end
        RX_START: begin
          if (cnt == HALF_LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rxd_p1 ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= RX_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt == BIT_LAST) begin
            cnt        <= '0;
            byte_valid <= rxd_p1;
            byte_ferr  <= !rxd_p1;
            state      <= RX_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == RX_DATA && cnt == BIT_LAST) byte_data <= {rxd_p1, byte_data[7:1]};
  end

endmodule

// File: rtl/board_link_rx.sv
// Board-link frame receiver: hunts for the header, collects six payload bytes,
// validates checksum/reserved bit/column and publishes good frames.
module board_link_rx
  import link_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int BYTE_TIMEOUT = 8680,
  parameter int LINK_TIMEOUT = 50_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rxd,
  output logic [COLOR_W-1:0] color_p1,
  output logic [COL_W-1:0]   selected_col_1_changed,
  output logic               fsm0_enable_1_changed,
  output logic               fsm1_enable_1_changed,
  output logic               frame_valid,
  output logic               frame_err,
  output logic               link_up
);

  localparam int               GAP_W   = $clog2(BYTE_TIMEOUT + 1);
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(BYTE_TIMEOUT);
  localparam int               WD_W    = $clog2(LINK_TIMEOUT + 1);
  localparam logic [WD_W-1:0]  WD_MAX  = WD_W'(LINK_TIMEOUT);
  localparam logic [2:0]       IDX_LAST = 3'(FRAME_PAYLOAD_BYTES - 1);

  function automatic logic [GAP_W-1:0] gap_sat_inc(input logic [GAP_W-1:0] v);
    return (v == GAP_MAX) ? v : v + 1'b1;
  endfunction

  function automatic logic [WD_W-1:0] wd_sat_inc(input logic [WD_W-1:0] v);
    return (v == WD_MAX) ? v : v + 1'b1;
  endfunction

  link_state_t      state;
  logic [2:0]       idx;
  logic [7:0]       csum;
  logic [GAP_W-1:0] gap;
  logic [WD_W-1:0]  wd;
  logic [PAY_W-1:0] pay;
  logic [7:0]       byte_data;
  logic             byte_valid, byte_ferr;
  logic             byte_evt, in_frame, gap_expired, frame_ok, commit;
  logic [WD_W-1:0]  wd_next;

  uart_byte_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte_rx (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rxd),
    .byte_data (byte_data),
    .byte_valid(byte_valid),
    .byte_ferr (byte_ferr)
  );

  assign byte_evt    = byte_valid || byte_ferr;
  assign in_frame    = (state == ST_PAYLOAD) || (state == ST_CHECK);
  assign gap_expired = (gap == GAP_MAX) && !byte_evt;
  assign frame_ok    = (byte_data == csum) && !pay[RSVD_BIT] &&
                       (pay[COL_LSB +: COL_W] <= COL_W'(COL_MAX));
  assign commit      = (state == ST_CHECK) && byte_valid && frame_ok;
  assign wd_next     = wd_sat_inc(wd);

  // Payload bytes shift in from the top so P0 ends up in bits [7:0]
  always_ff @(posedge clk) begin
    if (state == ST_PAYLOAD && byte_valid) pay <= {byte_data, pay[PAY_W-1:8]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                  <= ST_HUNT;
      idx                    <= '0;
      csum                   <= '0;
      gap                    <= '0;
      wd                     <= WD_MAX;
      link_up                <= 1'b0;
      frame_valid            <= 1'b0;
      frame_err              <= 1'b0;
      color_p1               <= '0;
      selected_col_1_changed <= '0;
      fsm0_enable_1_changed  <= 1'b0;
      fsm1_enable_1_changed  <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      gap         <= (byte_evt || !in_frame) ? '0 : gap_sat_inc(gap);

      // A commit landing on the expiry cycle keeps the link up
      if (commit) begin
        wd      <= '0;
        link_up <= 1'b1;
      end else begin
        wd <= wd_next;
        if (wd_next == WD_MAX) link_up <= 1'b0;
      end

      case (state)
        ST_HUNT: begin
          if (byte_valid && byte_data == LINK_HDR) begin
            state <= ST_PAYLOAD;
            idx   <= '0;
            csum  <= '0;
          end
        end
        ST_PAYLOAD: begin
          if (byte_ferr || gap_expired) begin
            state     <= ST_ERR;
            frame_err <= 1'b1;
          end else if (byte_valid) begin
            csum <= csum ^ byte_data;
            if (idx == IDX_LAST) state <= ST_CHECK;
            else                 idx   <= idx + 1'b1;
          end
        end
        ST_CHECK: begin
          if (commit) begin
            state                  <= ST_COMMIT;
            frame_valid            <= 1'b1;
            color_p1               <= pay[COLOR_LSB +: COLOR_W];
            selected_col_1_changed <= pay[COL_LSB +: COL_W];
            fsm0_enable_1_changed  <= pay[EN0_BIT];
            fsm1_enable_1_changed  <= pay[EN1_BIT];
          end else if (byte_evt || gap_expired) begin
            state     <= ST_ERR;
            frame_err <= 1'b1;
          end
        end
        ST_COMMIT: state <= ST_HUNT;
        ST_ERR:    state <= ST_HUNT;
        default:   state <= ST_HUNT;
      endcase
    end
  end

endmodule

// File: tb/tb_board_link_rx.sv
// Randomized self-checking bench for board_link_rx with a frame-level
// reference model (expected outputs derived from the serial byte stream).
module tb_board_link_rx;

  localparam int CPB = 8;
  localparam int BT  = 200;
  localparam int LT  = 4000;

  logic        clk, rst, rxd;
  logic [41:0] color_p1;
  logic [2:0]  selected_col_1_changed;
  logic        fsm0_enable_1_changed, fsm1_enable_1_changed;
  logic        frame_valid, frame_err, link_up;

  board_link_rx #(.CLKS_PER_BIT(CPB), .BYTE_TIMEOUT(BT), .LINK_TIMEOUT(LT)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .rxd                   (rxd),
    .color_p1              (color_p1),
    .selected_col_1_changed(selected_col_1_changed),
    .fsm0_enable_1_changed (fsm0_enable_1_changed),
    .fsm1_enable_1_changed (fsm1_enable_1_changed),
    .frame_valid           (frame_valid),
    .frame_err             (frame_err),
    .link_up               (link_up)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_fv    = 0;
  int n_fe    = 0;

  logic [41:0] exp_color = '0;
  logic [2:0]  exp_col   = '0;
  logic        exp_en0   = 1'b0;
  logic        exp_en1   = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (frame_valid) n_fv++;
      if (frame_err)   n_fe++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge clk) rxd = 1'b0;
    repeat (CPB - 1) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk) rxd = b[i];
      repeat (CPB - 1) @(negedge clk);
    end
    @(negedge clk) rxd = stop_bit;
    repeat (CPB - 1) @(negedge clk);
    @(negedge clk) rxd = 1'b1;
  endtask

  // Frame word: byte i of the serial stream sits at bits [8i+7:8i]
  function automatic logic [63:0] build_frame(input logic [41:0] color, input logic [2:0] col,
                                              input logic en0, input logic en1,
                                              input logic rsvd, input logic [7:0] bad_xor);
    logic [47:0] p;
    logic [7:0]  c;
    p = {rsvd, en1, en0, col, color[41:40], color[39:0]};
    c = bad_xor;
    for (int i = 0; i < 6; i++) c = c ^ p[8*i +: 8];
    return {c, p, 8'hA5};
  endfunction

  function automatic logic model_good(input logic [63:0] f);
    logic [7:0] x;
    x = 8'h00;
    for (int i = 1; i <= 6; i++) x = x ^ f[8*i +: 8];
    return (f[7:0] == 8'hA5) && (x == f[63:56]) && !f[55] && (f[52:50] <= 3'd6);
  endfunction

  function automatic logic [63:0] rand_good();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return build_frame(r[41:0], 3'($urandom_range(0, 6)), r[42], r[43], 1'b0, 8'h00);
  endfunction

  task automatic check_data(input string tag);
    chk({tag, "_color"}, 64'(color_p1), 64'(exp_color));
    chk({tag, "_col"},   64'(selected_col_1_changed), 64'(exp_col));
    chk({tag, "_en0"},   64'(fsm0_enable_1_changed), 64'(exp_en0));
    chk({tag, "_en1"},   64'(fsm1_enable_1_changed), 64'(exp_en1));
  endtask

  // ferr_at: byte sent with a low stop bit; stall_at: byte after which the line idles
  task automatic run_frame(input logic [63:0] f, input int ferr_at, input int stall_at,
                           input string tag);
    int   fv0, fe0;
    logic good;
    fv0  = n_fv;
    fe0  = n_fe;
    good = model_good(f) && (ferr_at < 0) && (stall_at < 0);
    for (int i = 0; i < 8; i++) begin
      send_byte(f[8*i +: 8], (i != ferr_at));
      if (i == ferr_at) break;
      if (i == stall_at) begin
        repeat (BT + 50) @(negedge clk);
        break;
      end
      repeat (2) @(negedge clk);
    end
    repeat (8) @(negedge clk);
    if (good) begin
      exp_color = {f[49:48], f[47:8]};
      exp_col   = f[52:50];
      exp_en0   = f[53];
      exp_en1   = f[54];
    end
    chk({tag, "_fv"}, 64'(n_fv - fv0), good ? 64'd1 : 64'd0);
    chk({tag, "_fe"}, 64'(n_fe - fe0), good ? 64'd0 : 64'd1);
    check_data(tag);
    if (good) chk({tag, "_link"}, 64'(link_up), 64'd1);
  endtask

  initial begin
    int fv0, fe0;
    rst = 1'b1;
    rxd = 1'b1;
    repeat (5) @(negedge clk);
    check_data("rst");
    chk("rst_fv",   64'(frame_valid), 64'd0);
    chk("rst_fe",   64'(frame_err),   64'd0);
    chk("rst_link", 64'(link_up),     64'd0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    run_frame(64'hCD4C_0000_0000_81A5, -1, -1, "good");
    chk("good_color_abs", 64'(color_p1), 64'h81);
    chk("good_col_abs",   64'(selected_col_1_changed), 64'd3);
    run_frame(64'hCC4C_0000_0000_81A5, -1, -1, "badcsum");
    run_frame(64'h1C1C_0000_0000_00A5, -1, -1, "col7");
    run_frame(64'h8080_0000_0000_00A5, -1, -1, "rsvd");

    fv0 = n_fv;
    fe0 = n_fe;
    send_byte(8'h3C, 1'b1);
    repeat (3) @(negedge clk);
    send_byte(8'hFF, 1'b1);
    repeat (5) @(negedge clk);
    chk("garbage_fv", 64'(n_fv - fv0), 64'd0);
    chk("garbage_fe", 64'(n_fe - fe0), 64'd0);
    run_frame(rand_good(), -1, -1, "resync");

    run_frame(rand_good(), -1, 3, "stall");
    run_frame(rand_good(), -1, -1, "after_stall");
    run_frame(rand_good(), 4, -1, "ferr");
    run_frame(rand_good(), -1, -1, "after_ferr");

    fv0 = n_fv;
    fe0 = n_fe;
    @(negedge clk) rxd = 1'b0;
    @(negedge clk) rxd = 1'b1;
    repeat (4 * CPB) @(negedge clk);
    chk("glitch_fv", 64'(n_fv - fv0), 64'd0);
    chk("glitch_fe", 64'(n_fe - fe0), 64'd0);
    run_frame(rand_good(), -1, -1, "after_glitch");

    for (int k = 0; k < 12; k++) begin
      logic [63:0] r;
      logic [7:0]  bx;
      r  = {$urandom(), $urandom()};
      bx = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      run_frame(build_frame(r[41:0], 3'($urandom_range(0, 7)), r[42], r[43],
                            ($urandom_range(0, 5) == 0), bx), -1, -1, $sformatf("rnd%0d", k));
    end

    run_frame(rand_good(), -1, -1, "pre_to");
    repeat (LT - 100) @(negedge clk);
    chk("to_link_before", 64'(link_up), 64'd1);
    repeat (150) @(negedge clk);
    chk("to_link_after", 64'(link_up), 64'd0);
    check_data("to_hold");

    run_frame(rand_good(), -1, -1, "pre_rst");
    send_byte(8'hA5, 1'b1);
    send_byte(8'h5A, 1'b1);
    send_byte(8'h33, 1'b1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    exp_color = '0;
    exp_col   = '0;
    exp_en0   = 1'b0;
    exp_en1   = 1'b0;
    check_data("midrst");
    chk("midrst_link", 64'(link_up), 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    run_frame(rand_good(), -1, -1, "after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
